backdoor_access_engine: RTL and testbench

BACKDOOR_ACCESS_ENGINE -- requirements
Module: backdoor_access_engine

---
 rtl/backdoor_access_engine_pkg.sv | 32 +++
 rtl/backdoor_access_engine_if.sv | 55 +++++
 rtl/backdoor_sd_byte_seq.sv | 50 +++++
 rtl/backdoor_access_engine.sv | 215 +++++++++++++++++++++
 tb/tb_backdoor_access_engine.sv | 436 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/backdoor_access_engine_pkg.sv
// Shared types for the backdoor access engine: FSM states,
// target-select constants, the registered request bundle and helpers.
package backdoor_pkg;

   localparam logic SEL_MAINMEM = 1'b0;
   localparam logic SEL_SDFLASH = 1'b1;

   // Width of the SD byte counter; covers SD_BYTES up to 8.
   localparam int IDX_W = 3;

   typedef enum logic [2:0] {
      IDLE,
      MEM_WR,
      MEM_RD,
      MEM_CAP,
      SD_OP,
      SD_WAIT,
      RESP
   } state_e;

   typedef struct packed {
      logic        write;
      logic        sel;
      logic [31:0] addr;
      logic [63:0] wdata;
   } req_t;

   function automatic logic misaligned(input logic [31:0] addr);
      return addr[2:0] != 3'b000;
   endfunction

endpackage

// File: rtl/backdoor_access_engine_if.sv
// Bus bundle between the system driver, scratchpad memory and SD flash.
// slave: engine view (request in, response/memory/SD commands out); master: environment view.
interface backdoor_access_engine_if #(
   parameter int MEM_AW = 29
);
   logic              req_valid;
   logic              req_ready;
   logic              req_write;
   logic              req_sel;
   logic [31:0]       req_addr;
   logic [63:0]       req_wdata;

   logic              rsp_valid;
   logic              rsp_ready;
   logic [63:0]       rsp_rdata;
   logic              rsp_err;

   logic              mem_in_reset;
   logic              mem_req;
   logic              mem_write;
   logic [7:0]        mem_mask;
   logic [MEM_AW-1:0] mem_addr;
   logic [63:0]       mem_wdata;
   logic [63:0]       mem_rdata;

   logic              sd_ready;
   logic              sd_wr_en;
   logic              sd_rd_en;
   logic [31:0]       sd_addr;
   logic [7:0]        sd_wdata;
   logic [7:0]        sd_rdata;

   modport slave (
      input  req_valid, req_write, req_sel, req_addr, req_wdata,
      output req_ready,
      output rsp_valid, rsp_rdata, rsp_err,
      input  rsp_ready,
      input  mem_in_reset, mem_rdata,
      output mem_req, mem_write, mem_mask, mem_addr, mem_wdata,
      input  sd_ready, sd_rdata,
      output sd_wr_en, sd_rd_en, sd_addr, sd_wdata
   );

   modport master (
      output req_valid, req_write, req_sel, req_addr, req_wdata,
      input  req_ready,
      input  rsp_valid, rsp_rdata, rsp_err,
      output rsp_ready,
      output mem_in_reset, mem_rdata,
      input  mem_req, mem_write, mem_mask, mem_addr, mem_wdata,
      output sd_ready, sd_rdata,
      input  sd_wr_en, sd_rd_en, sd_addr, sd_wdata
   );

endinterface

// File: rtl/backdoor_sd_byte_seq.sv
// SD byte sequencer: byte counter and little-endian read-data assembly.
// Ports: clr_i restarts, step_i advances (cap_i also stores rdata_i), idx_o/last_o/data_o status.
module backdoor_sd_byte_seq
   import backdoor_pkg::*;
#(
   parameter int SD_BYTES = 8
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             clr_i,
   input  logic             step_i,
   input  logic             cap_i,
   input  logic [7:0]       rdata_i,
   output logic [IDX_W-1:0] idx_o,
   output logic             last_o,
   output logic [63:0]      data_o
);

   logic [IDX_W-1:0] idx_q, idx_d;
   logic [63:0]      data_q, data_d;

   assign last_o = (idx_q == IDX_W'(SD_BYTES - 1));
   assign idx_o  = idx_q;
   assign data_o = data_q;

   always_comb begin
      idx_d  = idx_q;
      data_d = data_q;
      if (clr_i) begin
         idx_d  = '0;
         data_d = '0;
      end else if (step_i) begin
         if (cap_i) begin
            data_d[{idx_q, 3'b000} +: 8] = rdata_i;
         end
         idx_d = last_o ? '0 : idx_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         idx_q  <= '0;
         data_q <= '0;
      end else begin
         idx_q  <= idx_d;
         data_q <= data_d;
      end
   end

endmodule

// File: rtl/backdoor_access_engine.sv
// Backdoor access engine: one request at a time to scratchpad memory or SD flash.
// Ports: clk, rstn, bus (slave modport). SD path compiled in with BACKDOOR_SDFLASH_EN.
module backdoor_access_engine
   import backdoor_pkg::*;
#(
   parameter int MEM_AW   = 29,
   parameter int SD_BYTES = 8
) (
   input logic                     clk,
   input logic                     rstn,
   backdoor_access_engine_if.slave bus
);

   state_e            state_q;
   req_t              req_q;
   req_t              req_d;
   logic              live_q;
   logic              rsp_valid_q;
   logic              rsp_err_q;
   logic [63:0]       rdata_q;
   logic              mem_req_q;
   logic              mem_write_q;
   logic [7:0]        mem_mask_q;
   logic [MEM_AW-1:0] mem_addr_q;
   logic [63:0]       mem_wdata_q;
   logic              req_ready_d;
   logic              accept_d;

   // live_q keeps the first acceptance off the first edge after reset.
   assign req_ready_d = (state_q == IDLE) & live_q & ~bus.mem_in_reset;
   assign accept_d    = req_ready_d & bus.req_valid;

   assign req_d = '{
      write: bus.req_write,
      sel:   bus.req_sel,
      addr:  bus.req_addr,
      wdata: bus.req_wdata
   };

`ifdef BACKDOOR_SDFLASH_EN
   logic             sd_wr_q;
   logic             sd_rd_q;
   logic             ph_q;
   logic [31:0]      sd_addr_q;
   logic [7:0]       sd_wdata_q;
   logic [IDX_W-1:0] sd_idx;
   logic             sd_last;
   logic [63:0]      sd_data;
   logic             seq_step;
   logic [31:0]      sd_addr_d;
   logic [7:0]       sd_byte_d;
   logic             unused_sel;

   // Read data arrives the cycle after the strobe, so SD_WAIT spends
   // one cycle on the strobe (ph_q=0) and one on the capture (ph_q=1).
   assign seq_step  = (state_q == SD_WAIT) & ph_q;
   assign sd_addr_d = req_q.addr + {{(32 - IDX_W){1'b0}}, sd_idx};
   assign sd_byte_d = req_q.wdata[{sd_idx, 3'b000} +: 8];
   assign unused_sel = req_q.sel;

   backdoor_sd_byte_seq #(
      .SD_BYTES (SD_BYTES)
   ) u_seq (
      .clk     (clk),
      .rstn    (rstn),
      .clr_i   (accept_d),
      .step_i  (seq_step),
      .cap_i   (~req_q.write),
      .rdata_i (bus.sd_rdata),
      .idx_o   (sd_idx),
      .last_o  (sd_last),
      .data_o  (sd_data)
   );

   assign bus.sd_wr_en  = sd_wr_q;
   assign bus.sd_rd_en  = sd_rd_q;
   assign bus.sd_addr   = sd_addr_q;
   assign bus.sd_wdata  = sd_wdata_q;
   // Both sources are cleared on acceptance, only one is ever filled.
   assign bus.rsp_rdata = rdata_q | sd_data;
`else
   logic unused_sd;

   assign unused_sd = ^{bus.sd_ready, bus.sd_rdata, req_q, (SD_BYTES != 0)};

   assign bus.sd_wr_en  = 1'b0;
   assign bus.sd_rd_en  = 1'b0;
   assign bus.sd_addr   = '0;
   assign bus.sd_wdata  = '0;
   assign bus.rsp_rdata = rdata_q;
`endif

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q     <= IDLE;
         req_q       <= '0;
         live_q      <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rdata_q     <= '0;
         mem_req_q   <= 1'b0;
         mem_write_q <= 1'b0;
         mem_mask_q  <= '0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
`ifdef BACKDOOR_SDFLASH_EN
         sd_wr_q     <= 1'b0;
         sd_rd_q     <= 1'b0;
         ph_q        <= 1'b0;
         sd_addr_q   <= '0;
         sd_wdata_q  <= '0;
`endif
      end else begin
         live_q      <= 1'b1;
         mem_req_q   <= 1'b0;
         mem_write_q <= 1'b0;
         mem_mask_q  <= '0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
`ifdef BACKDOOR_SDFLASH_EN
         sd_wr_q     <= 1'b0;
         sd_rd_q     <= 1'b0;
`endif
         unique case (state_q)
            IDLE: begin
               if (accept_d) begin
                  req_q     <= req_d;
                  rdata_q   <= '0;
                  rsp_err_q <= 1'b0;
                  if (req_d.sel == SEL_SDFLASH) begin
`ifdef BACKDOOR_SDFLASH_EN
                     ph_q    <= 1'b0;
                     state_q <= SD_OP;
`else
                     rsp_err_q   <= 1'b1;
                     rsp_valid_q <= 1'b1;
                     state_q     <= RESP;
`endif
                  end else begin
                     // Misalignment is flagged but the access still
                     // goes out with the low address bits dropped.
                     rsp_err_q   <= misaligned(req_d.addr);
                     mem_req_q   <= 1'b1;
                     mem_write_q <= req_d.write;
                     mem_mask_q  <= req_d.write ? 8'hFF : 8'h00;
                     mem_addr_q  <= req_d.addr[MEM_AW+2:3];
                     mem_wdata_q <= req_d.write ? req_d.wdata : '0;
                     state_q     <= req_d.write ? MEM_WR : MEM_RD;
                  end
               end
            end
            MEM_WR: begin
               rsp_valid_q <= 1'b1;
               state_q     <= RESP;
            end
            MEM_RD: begin
               state_q <= MEM_CAP;
            end
            MEM_CAP: begin
               rdata_q     <= bus.mem_rdata;
               rsp_valid_q <= 1'b1;
               state_q     <= RESP;
            end
`ifdef BACKDOOR_SDFLASH_EN
            SD_OP: begin
               if (bus.sd_ready) begin
                  sd_wr_q    <= req_q.write;
                  sd_rd_q    <= ~req_q.write;
                  sd_addr_q  <= sd_addr_d;
                  sd_wdata_q <= sd_byte_d;
                  ph_q       <= 1'b0;
                  state_q    <= SD_WAIT;
               end
            end
            SD_WAIT: begin
               if (!ph_q) begin
                  ph_q <= 1'b1;
               end else begin
                  ph_q <= 1'b0;
                  if (sd_last) begin
                     rsp_valid_q <= 1'b1;
                     state_q     <= RESP;
                  end else begin
                     state_q <= SD_OP;
                  end
               end
            end
`else
            SD_OP, SD_WAIT: begin
               state_q <= IDLE;
            end
`endif
            RESP: begin
               if (bus.rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  state_q     <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign bus.req_ready = req_ready_d;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_err   = rsp_err_q;
   assign bus.mem_req   = mem_req_q;
   assign bus.mem_write = mem_write_q;
   assign bus.mem_mask  = mem_mask_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_backdoor_access_engine.sv
// Directed testbench for backdoor_access_engine.
// Memory and SD models are registered; SD scenarios build with BACKDOOR_SDFLASH_EN.
module tb_backdoor_access_engine;

   logic clk = 1'b0;
   logic rstn = 1'b0;
   int   total = 0;
   int   bad = 0;

   logic [63:0] mem_rd_val = '0;
   logic [63:0] mem_rdata_q = '0;
   logic [7:0]  sd_rdata_q = '0;
   logic        sd_toggle = 1'b0;
   logic        sd_fix = 1'b1;
   logic        tog_q = 1'b0;

   always #5 clk = ~clk;

   backdoor_access_engine_if #(.MEM_AW(29)) ifc ();

   backdoor_access_engine #(
      .MEM_AW   (29),
      .SD_BYTES (8)
   ) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (ifc.slave)
   );

   always @(posedge clk) begin
      tog_q <= ~tog_q;
      if (ifc.mem_req && !ifc.mem_write) mem_rdata_q <= mem_rd_val;
      if (ifc.sd_rd_en) sd_rdata_q <= ifc.sd_addr[7:0] ^ 8'hA5;
   end

   assign ifc.mem_rdata = mem_rdata_q;
   assign ifc.sd_rdata  = sd_rdata_q;
   assign ifc.sd_ready  = sd_toggle ? tog_q : sd_fix;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic w, input logic s, input logic [31:0] a,
                       input logic [63:0] d, output logic rdy);
      ifc.req_valid = 1'b1;
      ifc.req_write = w;
      ifc.req_sel   = s;
      ifc.req_addr  = a;
      ifc.req_wdata = d;
      #1;
      rdy = ifc.req_ready;
      @(posedge clk);
      #1;
      ifc.req_valid = 1'b0;
   endtask

   task automatic wait_rsp(output int n);
      n = -1;
      for (int k = 0; k < 50; k++) begin
         if (ifc.rsp_valid === 1'b1) begin
            n = k;
            break;
         end
         cyc();
      end
   endtask

   task automatic finish_rsp();
      ifc.rsp_ready = 1'b1;
      cyc();
      ifc.rsp_ready = 1'b0;
   endtask

   task automatic test_reset();
      repeat (3) cyc();
      total++;
      if ({ifc.req_ready, ifc.rsp_valid, ifc.rsp_err, ifc.mem_req,
           ifc.mem_write, ifc.sd_wr_en, ifc.sd_rd_en} !== 7'b0) begin
         bad++;
         $display("FAIL reset_ctl got=%b want=0", {ifc.req_ready, ifc.rsp_valid,
                  ifc.rsp_err, ifc.mem_req, ifc.mem_write, ifc.sd_wr_en, ifc.sd_rd_en});
      end
      total++;
      if ({ifc.mem_mask, ifc.mem_addr, ifc.sd_addr, ifc.sd_wdata} !== '0 ||
          ifc.rsp_rdata !== 64'h0) begin
         bad++;
         $display("FAIL reset_data mask=%h addr=%h rdata=%h want=0",
                  ifc.mem_mask, ifc.mem_addr, ifc.rsp_rdata);
      end
      rstn = 1'b1;
      #1;
      total++;
      if (ifc.req_ready !== 1'b0) begin
         bad++;
         $display("FAIL ready_early got=%b want=0", ifc.req_ready);
      end
      cyc();
      total++;
      if (ifc.req_ready !== 1'b1) begin
         bad++;
         $display("FAIL ready_second_edge got=%b want=1", ifc.req_ready);
      end
   endtask

   task automatic test_mem_write();
      logic rdy;
      send(1'b1, 1'b0, 32'h100, 64'hDEADBEEF_01234567, rdy);
      total++;
      if (rdy !== 1'b1) begin
         bad++;
         $display("FAIL wr_ready got=%b want=1", rdy);
      end
      total++;
      if ({ifc.mem_req, ifc.mem_write, ifc.mem_mask} !== {2'b11, 8'hFF}) begin
         bad++;
         $display("FAIL wr_ctl got=%b%b%h want=11ff", ifc.mem_req, ifc.mem_write, ifc.mem_mask);
      end
      total++;
      if (ifc.mem_addr !== 29'h20 || ifc.mem_wdata !== 64'hDEADBEEF_01234567) begin
         bad++;
         $display("FAIL wr_addr got=%h/%h want=20/deadbeef01234567", ifc.mem_addr, ifc.mem_wdata);
      end
      total++;
      if (ifc.rsp_valid !== 1'b0) begin
         bad++;
         $display("FAIL wr_rsp_early got=%b want=0", ifc.rsp_valid);
      end
      cyc();
      total++;
      if ({ifc.rsp_valid, ifc.rsp_err, ifc.mem_req} !== 3'b100 || ifc.rsp_rdata !== 64'h0) begin
         bad++;
         $display("FAIL wr_rsp got=%b%b%b/%h want=100/0", ifc.rsp_valid, ifc.rsp_err,
                  ifc.mem_req, ifc.rsp_rdata);
      end
      finish_rsp();
      total++;
      if (ifc.rsp_valid !== 1'b0) begin
         bad++;
         $display("FAIL wr_rsp_drop got=%b want=0", ifc.rsp_valid);
      end
   endtask

   task automatic test_mem_read();
      logic rdy;
      mem_rd_val = 64'hDEADBEEF_01234567;
      send(1'b0, 1'b0, 32'h100, 64'h0, rdy);
      total++;
      if ({rdy, ifc.mem_req, ifc.mem_write, ifc.mem_mask} !== {3'b110, 8'h00}) begin
         bad++;
         $display("FAIL rd_ctl got=%b%b%b%h want=11000", rdy, ifc.mem_req, ifc.mem_write, ifc.mem_mask);
      end
      cyc();
      total++;
      if (ifc.rsp_valid !== 1'b0 || ifc.mem_req !== 1'b0) begin
         bad++;
         $display("FAIL rd_cap got=%b%b want=00", ifc.rsp_valid, ifc.mem_req);
      end
      cyc();
      total++;
      if (ifc.rsp_valid !== 1'b1 || ifc.rsp_err !== 1'b0 ||
          ifc.rsp_rdata !== 64'hDEADBEEF_01234567) begin
         bad++;
         $display("FAIL rd_rsp got=%b%b/%h want=10/deadbeef01234567",
                  ifc.rsp_valid, ifc.rsp_err, ifc.rsp_rdata);
      end
      finish_rsp();
   endtask

   task automatic test_misaligned_stall();
      logic rdy;
      mem_rd_val = 64'h11223344_55667788;
      send(1'b0, 1'b0, 32'h103, 64'h0, rdy);
      total++;
      if (ifc.mem_req !== 1'b1 || ifc.mem_addr !== 29'h20) begin
         bad++;
         $display("FAIL mis_addr got=%b/%h want=1/20", ifc.mem_req, ifc.mem_addr);
      end
      cyc();
      cyc();
      for (int k = 0; k < 5; k++) begin
         total++;
         if (ifc.rsp_valid !== 1'b1 || ifc.rsp_err !== 1'b1 ||
             ifc.rsp_rdata !== 64'h11223344_55667788) begin
            bad++;
            $display("FAIL mis_hold%0d got=%b%b/%h want=11/1122334455667788",
                     k, ifc.rsp_valid, ifc.rsp_err, ifc.rsp_rdata);
         end
         cyc();
      end
      finish_rsp();
      total++;
      if (ifc.rsp_valid !== 1'b0 || ifc.req_ready !== 1'b1) begin
         bad++;
         $display("FAIL mis_release got=%b%b want=01", ifc.rsp_valid, ifc.req_ready);
      end
   endtask

   task automatic test_mem_in_reset();
      ifc.mem_in_reset = 1'b1;
      #1;
      total++;
      if (ifc.req_ready !== 1'b0) begin
         bad++;
         $display("FAIL mir_block got=%b want=0", ifc.req_ready);
      end
      ifc.req_valid = 1'b1;
      ifc.req_write = 1'b1;
      ifc.req_sel   = 1'b0;
      ifc.req_addr  = 32'h300;
      ifc.req_wdata = 64'hA5;
      cyc();
      cyc();
      total++;
      if (ifc.mem_req !== 1'b0) begin
         bad++;
         $display("FAIL mir_noreq got=%b want=0", ifc.mem_req);
      end
      ifc.mem_in_reset = 1'b0;
      cyc();
      ifc.req_valid = 1'b0;
      total++;
      if (ifc.mem_req !== 1'b1 || ifc.mem_addr !== 29'h60) begin
         bad++;
         $display("FAIL mir_go got=%b/%h want=1/60", ifc.mem_req, ifc.mem_addr);
      end
      ifc.mem_in_reset = 1'b1;
      cyc();
      total++;
      if (ifc.rsp_valid !== 1'b1) begin
         bad++;
         $display("FAIL mir_complete got=%b want=1", ifc.rsp_valid);
      end
      finish_rsp();
      total++;
      if (ifc.req_ready !== 1'b0) begin
         bad++;
         $display("FAIL mir_reblock got=%b want=0", ifc.req_ready);
      end
      ifc.mem_in_reset = 1'b0;
      #1;
      total++;
      if (ifc.req_ready !== 1'b1) begin
         bad++;
         $display("FAIL mir_unblock got=%b want=1", ifc.req_ready);
      end
   endtask

   task automatic test_reset_mid();
      logic rdy;
      logic seen;
      int   n;
      mem_rd_val = 64'h0BAD;
      send(1'b0, 1'b0, 32'h180, 64'h0, rdy);
      cyc();
      rstn = 1'b0;
      #1;
      total++;
      if ({ifc.req_ready, ifc.rsp_valid, ifc.mem_req, ifc.sd_wr_en} !== 4'b0 ||
          ifc.rsp_rdata !== 64'h0 || ifc.mem_addr !== 29'h0) begin
         bad++;
         $display("FAIL rstmid_out got=%b%b%b/%h want=000/0", ifc.req_ready,
                  ifc.rsp_valid, ifc.mem_req, ifc.rsp_rdata);
      end
      rstn = 1'b1;
      seen = 1'b0;
      for (int k = 0; k < 4; k++) begin
         cyc();
         seen = seen | ifc.rsp_valid;
      end
      total++;
      if (seen !== 1'b0) begin
         bad++;
         $display("FAIL rstmid_norsp got=%b want=0", seen);
      end
      send(1'b1, 1'b0, 32'h40, 64'h77, rdy);
      wait_rsp(n);
      total++;
      if (rdy !== 1'b1 || n != 1 || ifc.rsp_err !== 1'b0) begin
         bad++;
         $display("FAIL rstmid_next got=%b/%0d/%b want=1/1/0", rdy, n, ifc.rsp_err);
      end
      finish_rsp();
   endtask

`ifdef BACKDOOR_SDFLASH_EN
   task automatic test_sd_write();
      logic rdy;
      int   n;
      int   ovl;
      n = 0;
      ovl = 0;
      sd_fix = 1'b1;
      send(1'b1, 1'b1, 32'h200, 64'h0807060504030201, rdy);
      for (int k = 0; k < 80; k++) begin
         if (ifc.rsp_valid === 1'b1) break;
         if (ifc.mem_req + ifc.sd_wr_en + ifc.sd_rd_en > 1) ovl++;
         if (ifc.sd_wr_en === 1'b1) begin
            total++;
            if (ifc.sd_addr !== 32'h200 + 32'(n) || ifc.sd_wdata !== 8'(n + 1)) begin
               bad++;
               $display("FAIL sdw_byte%0d got=%h/%h want=%h/%h", n, ifc.sd_addr,
                        ifc.sd_wdata, 32'h200 + 32'(n), 8'(n + 1));
            end
            n++;
         end
         cyc();
      end
      total++;
      if (n != 8 || ovl != 0 || ifc.rsp_valid !== 1'b1 || ifc.rsp_err !== 1'b0 ||
          ifc.rsp_rdata !== 64'h0) begin
         bad++;
         $display("FAIL sdw_done got=%0d/%0d/%b%b/%h want=8/0/10/0", n, ovl,
                  ifc.rsp_valid, ifc.rsp_err, ifc.rsp_rdata);
      end
      finish_rsp();
   endtask

   task automatic test_sd_read_wrap();
      logic        rdy;
      logic [31:0] last_a;
      int          n;
      n = 0;
      last_a = '1;
      sd_toggle = 1'b1;
      send(1'b0, 1'b1, 32'hFFFF_FFFC, 64'h0, rdy);
      for (int k = 0; k < 120; k++) begin
         if (ifc.rsp_valid === 1'b1) break;
         if (ifc.sd_rd_en === 1'b1) begin
            total++;
            if (ifc.sd_addr !== 32'hFFFF_FFFC + 32'(n) || ifc.sd_wr_en !== 1'b0) begin
               bad++;
               $display("FAIL sdr_addr%0d got=%h want=%h", n, ifc.sd_addr,
                        32'hFFFF_FFFC + 32'(n));
            end
            last_a = ifc.sd_addr;
            n++;
         end
         cyc();
      end
      sd_toggle = 1'b0;
      total++;
      if (n != 8 || last_a !== 32'h3 || ifc.rsp_valid !== 1'b1 ||
          ifc.rsp_rdata !== 64'hA6A7A4A5_5A5B5859) begin
         bad++;
         $display("FAIL sdr_done got=%0d/%h/%b/%h want=8/3/1/a6a7a4a55a5b5859",
                  n, last_a, ifc.rsp_valid, ifc.rsp_rdata);
      end
      finish_rsp();
   endtask

   task automatic test_sd_reset_mid();
      logic rdy;
      logic seen;
      int   n;
      n = 0;
      send(1'b1, 1'b1, 32'h200, 64'h0807060504030201, rdy);
      for (int k = 0; k < 40; k++) begin
         if (ifc.sd_wr_en === 1'b1) n++;
         if (n == 4) break;
         cyc();
      end
      rstn = 1'b0;
      #1;
      total++;
      if (n != 4 || {ifc.sd_wr_en, ifc.sd_rd_en, ifc.rsp_valid} !== 3'b0 ||
          ifc.sd_addr !== 32'h0 || ifc.sd_wdata !== 8'h0) begin
         bad++;
         $display("FAIL sdrst_out got=%0d/%b%b%b/%h want=4/000/0", n, ifc.sd_wr_en,
                  ifc.sd_rd_en, ifc.rsp_valid, ifc.sd_addr);
      end
      rstn = 1'b1;
      seen = 1'b0;
      for (int k = 0; k < 4; k++) begin
         cyc();
         seen = seen | ifc.rsp_valid | ifc.sd_wr_en;
      end
      total++;
      if (seen !== 1'b0) begin
         bad++;
         $display("FAIL sdrst_quiet got=%b want=0", seen);
      end
   endtask
`else
   task automatic test_sd_disabled();
      logic rdy;
      send(1'b0, 1'b1, 32'h200, 64'h0, rdy);
      total++;
      if ({rdy, ifc.rsp_valid, ifc.rsp_err} !== 3'b111 || ifc.rsp_rdata !== 64'h0) begin
         bad++;
         $display("FAIL sdoff_rsp got=%b%b%b/%h want=111/0", rdy, ifc.rsp_valid,
                  ifc.rsp_err, ifc.rsp_rdata);
      end
      total++;
      if ({ifc.sd_wr_en, ifc.sd_rd_en, ifc.mem_req} !== 3'b0) begin
         bad++;
         $display("FAIL sdoff_quiet got=%b%b%b want=000", ifc.sd_wr_en, ifc.sd_rd_en, ifc.mem_req);
      end
      finish_rsp();
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      ifc.req_valid    = 1'b0;
      ifc.req_write    = 1'b0;
      ifc.req_sel      = 1'b0;
      ifc.req_addr     = '0;
      ifc.req_wdata    = '0;
      ifc.rsp_ready    = 1'b0;
      ifc.mem_in_reset = 1'b0;
      test_reset();
      test_mem_write();
      test_mem_read();
      test_misaligned_stall();
      test_mem_in_reset();
      test_reset_mid();
`ifdef BACKDOOR_SDFLASH_EN
      test_sd_write();
      test_sd_read_wrap();
      test_sd_reset_mid();
      test_mem_write();
`else
      test_sd_disabled();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
